seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 4-bit "1101" detector FSM. It samples a qualified serial bit stream and compares it against a runtime-loadable PAT_W-bit pattern. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. It sits between a serial front end (shift/sync logic) and status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/sat_counter.sv | 20 ++
 rtl/seq_pattern_detector.sv | 89 ++++++++
 tb/tb_seq_pattern_detector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial pattern detector.
package seq_det_pkg;
  typedef enum logic {FILL, ARMED} det_state_t;

  localparam int          DEF_PAT_W     = 4;
  localparam int          DEF_CNT_W     = 8;
  localparam logic [31:0] DEF_RESET_PAT = 32'h0000_000D;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       count <= '0;
    else if (clr)                     count <= '0;
    else if (inc && (count != '1))    count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with runtime-loadable pattern, overlap select and
// saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = DEF_RESET_PAT[PAT_W-1:0]
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             load_pattern,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap_en,
  input  logic             count_clear,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int             FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  det_state_t       state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n, shreg_sh;
  logic [PAT_W-1:0] pattern_reg, pattern_n;
  logic [FW-1:0]    fill, fill_n, fill_inc;
  logic             hit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= FILL;
      shreg       <= '0;
      fill        <= '0;
      pattern_reg <= RESET_PAT;
      match       <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      fill        <= fill_n;
      pattern_reg <= pattern_n;
      match       <= hit;
    end
  end

  always_comb begin
    shreg_sh  = {shreg[PAT_W-2:0], serial_in};
    fill_inc  = (fill == FULL) ? FULL : fill + FW'(1);
    hit       = in_valid && !load_pattern && (fill_inc == FULL) &&
                (shreg_sh == pattern_reg);
    state_n   = state;
    shreg_n   = shreg;
    fill_n    = fill;
    pattern_n = pattern_reg;

    if (load_pattern) begin
      pattern_n = pattern_in;
      fill_n    = '0;
      state_n   = FILL;
    end else if (in_valid) begin
      shreg_n = shreg_sh;
      // Non-overlapping mode discards the matched bits by restarting the fill.
      if (hit && !overlap_en) begin
        fill_n  = '0;
        state_n = FILL;
      end else begin
        fill_n = fill_inc;
        case (state)
          FILL:    state_n = (fill_inc == FULL) ? ARMED : FILL;
          ARMED:   state_n = ARMED;
          default: state_n = FILL;
        endcase
      end
    end
  end

  assign armed = (state == ARMED);

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (hit),
    .clr   (count_clear),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: default 4-bit detector, a CNT_W=2 variant and a PAT_W=8 variant.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serial_in = 1'b0, in_valid = 1'b0, load_pattern = 1'b0;
  logic       overlap_en = 1'b0, count_clear = 1'b0;
  logic [3:0] pattern_in = 4'h0;
  logic [7:0] pattern_in_c = 8'h00;
  logic       match_a, armed_a, match_b, armed_b, match_c, armed_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector u_a (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .in_valid(in_valid),
    .load_pattern(load_pattern), .pattern_in(pattern_in), .overlap_en(overlap_en),
    .count_clear(count_clear), .match(match_a), .armed(armed_a), .match_count(cnt_a)
  );

  seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) u_b (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .in_valid(in_valid),
    .load_pattern(load_pattern), .pattern_in(pattern_in), .overlap_en(overlap_en),
    .count_clear(count_clear), .match(match_b), .armed(armed_b), .match_count(cnt_b)
  );

  seq_pattern_detector #(.PAT_W(8), .CNT_W(8)) u_c (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .in_valid(in_valid),
    .load_pattern(load_pattern), .pattern_in(pattern_in_c), .overlap_en(overlap_en),
    .count_clear(count_clear), .match(match_c), .armed(armed_c), .match_count(cnt_c)
  );

  // Inputs change and outputs are read 1 time unit after each rising edge.
  task automatic send(input logic b, output logic [2:0] m);
    serial_in = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    m = {match_c, match_b, match_a};
  endtask

  task automatic stream(input logic [31:0] bits, input int n,
                        output logic [31:0] ma, output logic [31:0] mb,
                        output logic [31:0] mc);
    logic [2:0] m;
    ma = '0; mb = '0; mc = '0;
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], m);
      ma = {ma[30:0], m[0]};
      mb = {mb[30:0], m[1]};
      mc = {mc[30:0], m[2]};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset;
    n_rst = 1'b0;
    in_valid = 1'b0; load_pattern = 1'b0; count_clear = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic do_load(input logic [3:0] p, input logic [7:0] pc, input logic b);
    pattern_in   = p;
    pattern_in_c = pc;
    load_pattern = 1'b1;
    in_valid     = 1'b1;
    serial_in    = b;
    @(posedge clk); #1;
    load_pattern = 1'b0;
    in_valid     = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] ma, mb, mc;
    #2;
    checks++; if ({match_a, armed_a, cnt_a} !== 10'b0) begin
      errors++; $display("FAIL reset_state: got %b exp 0", {match_a, armed_a, cnt_a});
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    overlap_en = 1'b1;
    stream(32'b1101, 4, ma, mb, mc);
    checks++; if (ma[3:0] !== 4'b0001) begin
      errors++; $display("FAIL reset_first_match: got %b exp 0001", ma[3:0]);
    end
    checks++; if (cnt_a !== 8'd1 || armed_a !== 1'b1) begin
      errors++; $display("FAIL reset_first_cnt: got cnt %0d armed %b exp 1 1", cnt_a, armed_a);
    end
    // Asynchronous reset while match and armed are both high.
    n_rst = 1'b0;
    #2;
    checks++; if ({match_a, armed_a, cnt_a} !== 10'b0) begin
      errors++; $display("FAIL reset_async: got %b exp 0", {match_a, armed_a, cnt_a});
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    do_load(4'b0000, 8'h00, 1'b0);
    stream(32'b11, 2, ma, mb, mc);
    n_rst = 1'b0;
    #2;
    checks++; if (armed_a !== 1'b0 || match_a !== 1'b0) begin
      errors++; $display("FAIL reset_midstream: got armed %b match %b exp 0 0", armed_a, match_a);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    stream(32'b1101, 4, ma, mb, mc);
    checks++; if (ma[3:0] !== 4'b0001 || cnt_a !== 8'd1) begin
      errors++; $display("FAIL reset_pat_revert: got %b cnt %0d exp 0001 cnt 1", ma[3:0], cnt_a);
    end
  endtask

  task automatic test_overlap;
    logic [31:0] ma, mb, mc;
    apply_reset();
    overlap_en = 1'b1;
    stream(32'b1101101, 7, ma, mb, mc);
    checks++; if (ma[6:0] !== 7'b0001001 || cnt_a !== 8'd2) begin
      errors++; $display("FAIL overlap_on: got %b cnt %0d exp 0001001 cnt 2", ma[6:0], cnt_a);
    end
    apply_reset();
    overlap_en = 1'b0;
    stream(32'b1101101, 7, ma, mb, mc);
    checks++; if (ma[6:0] !== 7'b0001000 || cnt_a !== 8'd1) begin
      errors++; $display("FAIL overlap_off: got %b cnt %0d exp 0001000 cnt 1", ma[6:0], cnt_a);
    end
    checks++; if (armed_a !== 1'b0) begin
      errors++; $display("FAIL overlap_off_armed: got %b exp 0", armed_a);
    end
  endtask

  task automatic test_gaps;
    logic [3:0] bits = 4'b1101;
    logic [3:0] got  = '0;
    logic       extra = 1'b0;
    logic [2:0] m;
    apply_reset();
    overlap_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      send(bits[i], m);
      got = {got[2:0], m[0]};
      checks++; if (armed_a !== (i == 0)) begin
        errors++; $display("FAIL gaps_armed bit %0d: got %b exp %b", 3 - i, armed_a, (i == 0));
      end
      repeat (3) begin @(posedge clk); #1; extra = extra | match_a; end
    end
    checks++; if (got !== 4'b0001 || extra !== 1'b0) begin
      errors++; $display("FAIL gaps_match: got %b extra %b exp 0001 0", got, extra);
    end
  endtask

  task automatic test_load;
    logic [31:0] ma, mb, mc;
    apply_reset();
    overlap_en = 1'b1;
    stream(32'b110, 3, ma, mb, mc);
    do_load(4'b0110, 8'h00, 1'b1);
    checks++; if (armed_a !== 1'b0 || match_a !== 1'b0) begin
      errors++; $display("FAIL load_state: got armed %b match %b exp 0 0", armed_a, match_a);
    end
    stream(32'b0110, 4, ma, mb, mc);
    checks++; if (ma[3:0] !== 4'b0001 || cnt_a !== 8'd1) begin
      errors++; $display("FAIL load_match: got %b cnt %0d exp 0001 cnt 1", ma[3:0], cnt_a);
    end
    // A bit presented with the load must not start the new sequence.
    do_load(4'b0110, 8'h00, 1'b0);
    checks++; if (cnt_a !== 8'd1 || armed_a !== 1'b0) begin
      errors++; $display("FAIL load_keeps_cnt: got cnt %0d armed %b exp 1 0", cnt_a, armed_a);
    end
    stream(32'b1100, 4, ma, mb, mc);
    checks++; if (ma[3:0] !== 4'b0000) begin
      errors++; $display("FAIL load_bit_ignored: got %b exp 0000", ma[3:0]);
    end
    stream(32'b011, 3, ma, mb, mc);
    do_load(4'b0110, 8'h00, 1'b0);
    stream(32'b0110, 4, ma, mb, mc);
    checks++; if (ma[3:0] !== 4'b0001 || cnt_a !== 8'd2) begin
      errors++; $display("FAIL load_fill_restart: got %b cnt %0d exp 0001 cnt 2", ma[3:0], cnt_a);
    end
  endtask

  task automatic test_saturation;
    logic [31:0] ma, mb, mc;
    logic [2:0]  m;
    apply_reset();
    overlap_en = 1'b1;
    do_load(4'b1111, 8'h00, 1'b0);
    stream(32'hFF, 8, ma, mb, mc);
    checks++; if (mb[7:0] !== 8'b00011111) begin
      errors++; $display("FAIL sat_match: got %b exp 00011111", mb[7:0]);
    end
    checks++; if (cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
      errors++; $display("FAIL sat_count: got b %0d a %0d exp 3 5", cnt_b, cnt_a);
    end
    count_clear = 1'b1;
    send(1'b1, m);
    count_clear = 1'b0;
    checks++; if (m[1] !== 1'b1 || cnt_b !== 2'd0 || cnt_a !== 8'd0) begin
      errors++; $display("FAIL sat_clear_hit: got match %b b %0d a %0d exp 1 0 0", m[1], cnt_b, cnt_a);
    end
    send(1'b1, m);
    checks++; if (cnt_b !== 2'd1) begin
      errors++; $display("FAIL sat_after_clear: got %0d exp 1", cnt_b);
    end
  endtask

  task automatic test_width;
    logic [31:0] ma, mb, mc;
    logic [2:0]  r;
    apply_reset();
    overlap_en = 1'b0;
    do_load(4'h0, 8'hA5, 1'b0);
    r = 3'($urandom_range(0, 7));
    stream({21'b0, r, 8'hA5}, 11, ma, mb, mc);
    checks++; if (mc[10:0] !== 11'b00000000001 || cnt_c !== 8'd1) begin
      errors++; $display("FAIL width_match: got %b cnt %0d exp 00000000001 cnt 1", mc[10:0], cnt_c);
    end
    stream(32'b10100111, 8, ma, mb, mc);
    checks++; if (mc[7:0] !== 8'b0 || cnt_c !== 8'd1) begin
      errors++; $display("FAIL width_corrupt: got %b cnt %0d exp 0 cnt 1", mc[7:0], cnt_c);
    end
    stream(32'hA5, 8, ma, mb, mc);
    checks++; if (mc[7:0] !== 8'b00000001 || cnt_c !== 8'd2) begin
      errors++; $display("FAIL width_rematch: got %b cnt %0d exp 00000001 cnt 2", mc[7:0], cnt_c);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_gaps();
    test_load();
    test_saturation();
    test_width();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
